// File: rtl/memarb.sv
// memarb: 3-port round-robin arbiter in front of the tsdram command interface.
// Optional abort of stalled commands is enabled with `define MEMARB_TIMEOUT_EN.
module memarb #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req0,
  input  logic [1:0]  req1,
  input  logic [1:0]  req2,
  input  logic [1:0]  mask0,
  input  logic [1:0]  mask1,
  input  logic [1:0]  mask2,
  input  logic [25:0] addr0,
  input  logic [25:0] addr1,
  input  logic [25:0] addr2,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  input  logic [15:0] wdata2,
  output logic        ack0,
  output logic        ack1,
  output logic        ack2,
  output logic        dvalid0,
  output logic        dvalid1,
  output logic        dvalid2,
  output logic [1:0]  cmd_req,
  output logic [1:0]  cmd_mask,
  output logic [25:0] cmd_addr,
  output logic [15:0] cmd_din,
  input  logic        cmd_ack,
  input  logic        data_valid,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_END  = 2'd2
  } state_t;

  state_t state, state_n;

  // Fourth slot is a permanently idle dummy so 2-bit indices never fall off the end.
  logic [3:0][1:0]  req_v;
  logic [3:0][1:0]  mask_v;
  logic [3:0][25:0] addr_v;
  logic [3:0][15:0] wdata_v;
  logic [3:0]       pending;

  assign req_v   = {2'b00, req2, req1, req0};
  assign mask_v  = {2'b00, mask2, mask1, mask0};
  assign addr_v  = {26'd0, addr2, addr1, addr0};
  assign wdata_v = {16'd0, wdata2, wdata1, wdata0};

  always_comb begin
    for (int i = 0; i < 4; i++) pending[i] = |req_v[i];
  end

  logic [1:0] last, grant, owner;
  logic [1:0] c0, c1, c2, win;
  logic       any_pending;
  logic [2:0] ack_v;
  logic       expire;
  logic       do_latch, do_ack, do_abort;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    c0 = nxt(last);
    c1 = nxt(c0);
    c2 = nxt(c1);
    any_pending = |pending[2:0];
    if (pending[c0])      win = c0;
    else if (pending[c1]) win = c1;
    else                  win = c2;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = S_IDLE;
    case (state)
      S_IDLE:  state_n = any_pending ? S_WAIT : S_IDLE;
      S_WAIT:  state_n = (cmd_ack || expire) ? S_END : S_WAIT;
      S_END:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // An ack in the expiry cycle takes precedence over the abort.
  always_comb begin
    do_latch = (state == S_IDLE) && any_pending;
    do_ack   = (state == S_WAIT) && cmd_ack;
    do_abort = (state == S_WAIT) && !cmd_ack && expire;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cmd_req  <= 2'b00;
      cmd_mask <= 2'b00;
      cmd_addr <= 26'd0;
      cmd_din  <= 16'd0;
      ack_v    <= 3'b000;
      grant    <= 2'd0;
      last     <= 2'd2;
      owner    <= 2'd0;
    end else begin
      if (do_latch) begin
        cmd_req  <= req_v[win];
        cmd_mask <= mask_v[win];
        cmd_din  <= wdata_v[win];
        cmd_addr <= {addr_v[win][25:3], req_v[win][0] ? addr_v[win][2:0] : 3'b000};
        grant    <= win;
        last     <= win;
      end else if (do_ack || do_abort) begin
        cmd_req  <= 2'b00;
      end
      ack_v <= do_ack ? (3'b001 << grant) : 3'b000;
      if (do_ack) owner <= grant;
    end
  end

`ifdef MEMARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt <= 8'd0;
      err     <= 1'b0;
    end else begin
      err <= do_abort;
      if (do_latch)              tmo_cnt <= 8'd0;
      else if (state == S_WAIT)  tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  assign expire = (state == S_WAIT) && (tmo_cnt == TMO_LAST);
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
  assign expire = 1'b0;
  assign err    = 1'b0;
`endif

  assign ack0 = ack_v[0];
  assign ack1 = ack_v[1];
  assign ack2 = ack_v[2];

  assign dvalid0 = data_valid && (owner == 2'd0);
  assign dvalid1 = data_valid && (owner == 2'd1);
  assign dvalid2 = data_valid && (owner == 2'd2);

endmodule

// File: doc/memarb.md
# memarb

Three-port round-robin arbiter that shares the single `tsdram` command interface between bus masters (cache bus A, cache bus B, and a DMA/CD-buffer port). It replaces the fixed-priority request manager in front of the SDRAM controller.
- Latches one request at a time and drives it to the controller.
- Returns a one-cycle ack to the winning port.
- Routes the controller's `data_valid` strobe to the port that owns the current transfer.

## Interface
Parameters:
- `TIMEOUT`, 255, max cycles in WAITACK before abort (only with `MEMARB_TIMEOUT_EN`); 8-bit range, 1..255

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low reset; one clock, reset is synchronous and active-low
- `req0`, `req1`, `req2`  in  2 each  request code per port:
  - 00 none
  - 01 word write
  - 10 line read (8-byte aligned)
  - 11 word read
- `mask0`, `mask1`, `mask2`  in  2 each  byte mask per port
- `addr0`, `addr1`, `addr2`  in  26 each  byte address per port
- `wdata0`, `wdata1`, `wdata2`  in  16 each  write data per port
- `ack0`, `ack1`, `ack2`  out  1 each  one-cycle grant-complete pulse
- `dvalid0`, `dvalid1`, `dvalid2`  out  1 each  `data_valid` routed to owner
- `cmd_req`  out  2  request code to controller
- `cmd_mask`  out  2  mask to controller
- `cmd_addr`  out  26  address to controller
- `cmd_din`  out  16  write data to controller
- `cmd_ack`  in  1  controller accepted the command
- `data_valid`  in  1  controller read-data strobe
- `err`  out  1  timeout pulse (tied 0 without `MEMARB_TIMEOUT_EN`)

## Operation
- States: IDLE, WAITACK, END (2-bit; unused encodings go to IDLE).
- **IDLE**
  - A port is pending when its `reqN != 00`.
  - Search order starts at `last+1` and wraps mod 3 (2 wraps to 0). The first pending port in that order wins.
  - On a winner, the arbiter latches:
    - `cmd_req <= reqW`, `cmd_mask <= maskW`, `cmd_din <= wdataW`
    - `cmd_addr[25:3] <= addrW[25:3]`
    - `cmd_addr[2:0] <= reqW[0] ? addrW[2:0] : 0`
    - `grant <= W`, `last <= W`
  - It then moves to WAITACK. With no port pending, it stays in IDLE with `cmd_req = 0`.
- **WAITACK**
  - Command outputs are held stable.
  - On `cmd_ack=1`:
    - `cmd_req <= 0`
    - `ack[grant] <= 1`
    - `owner <= grant`
    - move to END
- **END**
  - All `ackN <= 0`, then move to IDLE.
- Data routing: `dvalidN = data_valid && owner==N`, combinational.
  - `owner` changes only on `cmd_ack`. It therefore stays valid for read data that arrives after the ack and before the next ack.
- Requester rule: a port drops `reqN` on the edge where it samples `ackN=1`. The arbiter samples requests only in IDLE, so a held request is treated as a new one.
- Request inputs seen outside IDLE are ignored; they are not queued internally.

## Timing
- Reset values (while `reset=0` at an edge):
  - state IDLE, `cmd_req=0`, `cmd_mask=0`, `cmd_addr=0`, `cmd_din=0`
  - all `ackN=0`, `err=0`, `grant=0`
  - `owner=0` (so `dvalid0=data_valid` after reset)
  - `last=2`, so port 0 wins the first arbitration
- Reset mid-transfer: the command is abandoned the next edge and no ack is issued.
- Latency:
  - Request seen in IDLE at edge n: `cmd_req` valid from n+1.
  - `cmd_ack` seen at edge m: `ackN` high during m+1..m+2, i.e. exactly one cycle.
  - Back to IDLE at m+2, so a new grant is possible with `cmd_req` valid from m+3.
- Minimum grant-to-grant spacing: 3 cycles plus controller ack latency.
- Simultaneous requests: resolved purely by rotation, so every pending port is served within 3 grants.

## Configuration
- `MEMARB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to WAITACK and increments each WAITACK cycle.
  - When it reaches `TIMEOUT` with no `cmd_ack`, the arbiter sets `cmd_req <= 0`, pulses `err` for one cycle and goes to END.
  - No `ackN` is issued and `owner` is unchanged.
  - `cmd_ack` arriving in the same cycle as the expiry wins: a normal ack is issued and `err` stays 0.
- `MEMARB_TIMEOUT_EN` undefined: no counter, `err` is constant 0, and WAITACK waits indefinitely.

## Test plan
- After reset, `req0=01`, `addr0=0x0000007`, `wdata0=0xA55A` -> next cycle `cmd_req=01`, `cmd_addr=0x0000007`, `cmd_din=0xA55A`; `cmd_ack` 2 cycles later -> `ack0` high for exactly 1 cycle, `cmd_req=0`.
- `req1=10`, `addr1=0x1234567` -> `cmd_addr=0x1234560`. Then 4 `data_valid` pulses -> only `dvalid1` toggles; `dvalid0` and `dvalid2` stay 0.
- All three ports hold requests continuously (re-asserting after each ack) -> grant order 0,1,2,0,1,2 over 6 grants.
- `req2=11` issued while port 0 is in WAITACK -> `req2` is not granted until after port 0's END; `cmd_mask` and `cmd_addr` hold port 0 values throughout.
- `reset=0` for one cycle during WAITACK -> next cycle all outputs at reset values, no `ackN` pulse; the next arbitration grants port 0 first.
- With `MEMARB_TIMEOUT_EN` and `TIMEOUT=4`, no `cmd_ack` -> `err` pulses once, 4 cycles after WAITACK entry, `cmd_req=0`, no `ack`; the arbiter returns to IDLE and serves the next pending port.
